// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, forward-select
// encodings and the shadow-pipeline entry types.
package riscv_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     wr;
        logic     ld;
    } dec_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     wr;
    } dst_t;

    // Memory-stage producer wins over writeback: it holds the newer value.
    function automatic logic [1:0] fwd_sel(input reg_idx_t src, input dst_t m, input dst_t w);
        if (src != '0 && m.wr && m.rd == src) begin
            return FWD_MEM;
        end else if (src != '0 && w.wr && w.rd == src) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational register-usage decode of the Decode-stage instruction.
module hazard_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic       use_rs1;
    logic       use_rs2;
    logic       writes;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign unused_fields = ^{instr[31:25], instr[14:12]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        writes  = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                writes  = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
                writes  = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                writes = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
                writes  = 1'b0;
            end
        endcase
    end

    // x0 is never recorded as a destination, so it can never be forwarded or stall.
    always_comb begin
        dec     = '0;
        dec.rs1 = use_rs1 ? instr[19:15] : '0;
        dec.rs2 = use_rs2 ? instr[24:20] : '0;
        dec.wr  = writes && (instr[11:7] != '0);
        dec.rd  = dec.wr ? instr[11:7] : '0;
        dec.ld  = (opcode == OP_LOAD);
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: shadow E/M/W register-usage pipeline, operand forwarding,
// load-use stall, branch flush and saturating stall/flush event counters.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      InstrD,
    input  logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    dec_t             dec_d;
    dec_t             e_d, e_q;
    dst_t             m_d, m_q;
    dst_t             w_d, w_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic             lw_stall;
    logic             hit_rs1;
    logic             hit_rs2;

    hazard_decode u_decode (
        .instr (InstrD),
        .dec   (dec_d)
    );

    always_comb begin
        hit_rs1  = (dec_d.rs1 != '0) && (dec_d.rs1 == e_q.rd);
        hit_rs2  = (dec_d.rs2 != '0) && (dec_d.rs2 == e_q.rd);
        lw_stall = e_q.ld && e_q.wr && (hit_rs1 || hit_rs2);
    end

    // A taken branch makes the Decode instruction wrong-path, so it overrides the stall.
    always_comb begin
        FlushD    = PCSrcE;
        FlushE    = lw_stall | PCSrcE;
        StallF    = lw_stall & ~PCSrcE;
        StallD    = lw_stall & ~PCSrcE;
        ForwardAE = fwd_sel(e_q.rs1, m_q, w_q);
        ForwardBE = fwd_sel(e_q.rs2, m_q, w_q);
    end

    always_comb begin
        e_d    = FlushE ? '0 : dec_d;
        m_d    = '0;
        m_d.rd = e_q.rd;
        m_d.wr = e_q.wr;
        w_d    = m_q;

        stall_cnt_d = stall_cnt_q;
        if (StallF && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (PCSrcE && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random
// instruction streams compared against an instruction-history reference model.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic        PCSrcE;

    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
    logic        stall_f4, stall_d4, flush_d4, flush_e4;
    logic [1:0]  fa4, fb4;
    logic [3:0]  sc4, fc4;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCSrcE(PCSrcE),
        .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d), .FlushE(flush_e),
        .ForwardAE(fa), .ForwardBE(fb), .stall_count(sc), .flush_count(fc)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCSrcE(PCSrcE),
        .StallF(stall_f4), .StallD(stall_d4), .FlushD(flush_d4), .FlushE(flush_e4),
        .ForwardAE(fa4), .ForwardBE(fb4), .stall_count(sc4), .flush_count(fc4)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the instructions now in E, M and W read and write.
    logic [4:0] e_rs1, e_rs2, e_rd, m_rd, w_rd;
    bit         e_wr, e_ld, m_wr, w_wr;
    longint     n_stall, n_flush;

    logic       obs_st, obs_sd, obs_fd, obs_fe;
    logic [1:0] obs_fa, obs_fb;
    logic [31:0] obs_sc, obs_fc;
    logic [3:0] obs_sc4;

    task automatic model_clear();
        e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_wr = 0; e_ld = 0;
        m_rd = 0; m_wr = 0; w_rd = 0; w_wr = 0;
        n_stall = 0; n_flush = 0;
    endtask

    task automatic decode(input logic [31:0] ins, output logic [4:0] rs1, output logic [4:0] rs2,
                          output logic [4:0] rd, output bit wr, output bit ld);
        bit r1, r2, w;
        case (ins[6:0])
            7'h33:        {r1, r2, w} = 3'b111;
            7'h13, 7'h03: {r1, r2, w} = 3'b101;
            7'h67:        {r1, r2, w} = 3'b101;
            7'h23, 7'h63: {r1, r2, w} = 3'b110;
            7'h6f, 7'h37, 7'h17: {r1, r2, w} = 3'b001;
            default:      {r1, r2, w} = 3'b000;
        endcase
        rs1 = r1 ? ins[19:15] : 5'd0;
        rs2 = r2 ? ins[24:20] : 5'd0;
        wr  = w && (ins[11:7] != 5'd0);
        rd  = wr ? ins[11:7] : 5'd0;
        ld  = (ins[6:0] == 7'h03);
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (m_wr && m_rd == src) return 2'd2;
        if (w_wr && w_rd == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic apply(input logic [31:0] ins, input bit pc, input bit rst);
        logic [4:0] d_rs1, d_rs2, d_rd;
        bit d_wr, d_ld, lw, ex_st, ex_fe;
        logic [31:0] sat4;
        InstrD = ins;
        PCSrcE = pc;
        reset  = rst;
        @(negedge clk);
        decode(ins, d_rs1, d_rs2, d_rd, d_wr, d_ld);
        lw    = e_ld && e_wr && ((d_rs1 != 0 && d_rs1 == e_rd) || (d_rs2 != 0 && d_rs2 == e_rd));
        ex_st = lw && !pc;
        ex_fe = lw || pc;
        sat4  = (n_stall > 15) ? 32'd15 : 32'(n_stall);
        chk("stall_f", stall_f, ex_st);
        chk("stall_d", stall_d, ex_st);
        chk("flush_d", flush_d, pc);
        chk("flush_e", flush_e, ex_fe);
        chk("fwd_a", fa, model_fwd(e_rs1));
        chk("fwd_b", fb, model_fwd(e_rs2));
        chk("stall_cnt", sc, 32'(n_stall));
        chk("flush_cnt", fc, 32'(n_flush));
        chk("stall_cnt4", sc4, sat4);
        chk("flush_cnt4", fc4, (n_flush > 15) ? 32'd15 : 32'(n_flush));
        chk("stall_f4", stall_f4, ex_st);
        chk("fwd_a4", {fa4, fb4, flush_d4, flush_e4, stall_d4},
            {model_fwd(e_rs1), model_fwd(e_rs2), pc, ex_fe, ex_st});
        obs_st = stall_f; obs_sd = stall_d; obs_fd = flush_d; obs_fe = flush_e;
        obs_fa = fa; obs_fb = fb; obs_sc = sc; obs_fc = fc; obs_sc4 = sc4;
        if (rst) begin
            model_clear();
        end else begin
            if (ex_st) n_stall++;
            if (pc) n_flush++;
            w_rd = m_rd; w_wr = m_wr;
            m_rd = e_rd; m_wr = e_wr;
            if (ex_fe) begin
                e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_wr = 0; e_ld = 0;
            end else begin
                e_rs1 = d_rs1; e_rs2 = d_rs2; e_rd = d_rd; e_wr = d_wr; e_ld = d_ld;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        logic [31:0] r;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1:    return i_add(a, b, c);
            2:       return {r[31:20], b, 3'd0, a, 7'h13};
            3, 4:    return i_lw(a, b);
            5:       return {7'd0, c, b, 3'b010, r[11:7], 7'h23};
            6:       return {7'd0, c, b, 3'd0, r[11:7], 7'h63};
            7:       return {r[31:12], a, 7'h6f};
            8:       return {r[31:20], b, 3'd0, a, 7'h67};
            default: return {r[31:7], 7'h7f};
        endcase
    endfunction

    initial begin
        reset = 1'b1; InstrD = '0; PCSrcE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();

        // Reset state.
        apply(32'd0, 0, 0);
        chk("rst_outs", {obs_st, obs_sd, obs_fd, obs_fe, obs_fa, obs_fb}, 32'd0);

        // Forward from M, then from W one gap later.
        apply(i_add(1, 2, 3), 0, 0);
        apply(i_add(4, 1, 5), 0, 0);
        apply(32'd0, 0, 0);
        chk("t1_fwd_mem", obs_fa, 32'd2);
        apply(i_add(1, 2, 3), 0, 0);
        apply(32'd0, 0, 0);
        apply(i_add(4, 1, 5), 0, 0);
        apply(32'd0, 0, 0);
        chk("t1_fwd_wb", obs_fa, 32'd1);

        // Load-use: one bubble, then writeback forwarding.
        apply(32'd0, 0, 1);
        apply(i_lw(1, 2), 0, 0);
        apply(i_add(3, 1, 1), 0, 0);
        chk("t2_stall", {obs_st, obs_sd, obs_fe}, 32'd7);
        apply(i_add(3, 1, 1), 0, 0);
        chk("t2_no_restall", obs_st, 32'd0);
        apply(32'd0, 0, 0);
        chk("t2_fwd", {obs_fa, obs_fb}, 32'b0101);
        chk("t2_cnt", obs_sc, 32'd1);

        // x0 load never stalls or forwards.
        apply(i_lw(0, 2), 0, 0);
        apply(i_add(3, 0, 0), 0, 0);
        chk("t3_stall", obs_st, 32'd0);
        apply(32'd0, 0, 0);
        chk("t3_fwd", {obs_fa, obs_fb}, 32'd0);

        // Taken branch overrides load-use stall.
        apply(32'd0, 0, 1);
        apply(i_lw(1, 2), 0, 0);
        apply(i_add(3, 1, 1), 1, 0);
        chk("t4_ctrl", {obs_st, obs_sd, obs_fd, obs_fe}, 32'b0011);
        apply(32'd0, 0, 0);
        chk("t4_fcnt", obs_fc, 32'd1);
        chk("t4_scnt", obs_sc, 32'd0);

        // M priority over W.
        apply(i_add(1, 2, 3), 0, 0);
        apply(i_add(1, 4, 5), 0, 0);
        apply(i_add(2, 1, 1), 0, 0);
        apply(32'd0, 0, 0);
        chk("t5_prio", {obs_fa, obs_fb}, 32'b1010);

        // Reset in the middle of a stall.
        apply(i_lw(1, 2), 0, 0);
        apply(i_add(3, 1, 1), 0, 1);
        chk("t6_mid_stall", obs_st, 32'd1);
        apply(32'd0, 0, 0);
        chk("t6_outs", {obs_st, obs_sd, obs_fd, obs_fe, obs_fa, obs_fb}, 32'd0);
        chk("t6_cnts", {obs_sc, obs_fc}, 32'd0);

        // 20 stalled cycles: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            apply(i_lw(1, 2), 0, 0);
            apply(i_add(2, 1, 1), 0, 0);
        end
        apply(32'd0, 0, 0);
        chk("sat4", obs_sc4, 32'd15);
        chk("sat32", obs_sc, 32'd20);

        // Random streams against the model.
        for (int i = 0; i < 600; i++) begin
            apply(rand_instr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
